// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//
// Single-port 32-bit word memory behind a byte-addressed request port. It
// returns registered read data and tracks access statistics and errors.
//
// Handshake: there is no ready signal. A request is a single cycle with
// sram_en=1. Every request seen while reset=0 is accepted in that cycle, and
// its response appears on sram_rdata after the next rising edge. sram_rdata
// then holds until the next accepted access.
//
// Optional feature (macro SRAM_RESP_WRITE_FWD_EN):
//   defined   - a write cycle loads sram_wdata into sram_rdata (write-first)
//   undefined - a write cycle loads the pre-write word into sram_rdata
//               (read-first)
//
// Parameters:
//   ADDR_WIDTH  word-address width, depth = 2**ADDR_WIDTH words
//   BASE_ADDR   byte address of word 0
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   sram_en     access request in this cycle
//   sram_we     write strobe (ignored when sram_en=0)
//   sram_addr   byte address
//   sram_wdata  write data
//   sram_rdata  registered read data
//   err         sticky error flag
//   err_addr    address of the first erroneous access since reset
//   err_cnt     saturating count of erroneous accesses
//   rd_cnt      accepted reads, wraps
//   wr_cnt      accepted writes, wraps
// -----------------------------------------------------------------------------
module sram_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [7:0]  err_cnt,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  // Byte span of the memory, kept at 33 bits so ADDR_WIDTH=30 still works.
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  logic [31:0]           mem [DEPTH];

  logic [31:0]           offset;
  logic                  in_range;
  logic                  access_err;
  logic [ADDR_WIDTH-1:0] index;
  logic                  accept;
  logic                  do_write;
  logic [31:0]           next_rdata;
  logic                  unused_offset_low;

  always_comb begin
    offset     = sram_addr - BASE_ADDR;
    in_range   = {1'b0, offset} < SPAN;
    index      = offset[ADDR_WIDTH+1:2];
    // Alignment is judged on the initiator's address, not the offset.
    access_err = !in_range || (sram_addr[1:0] != 2'b00);
    // Reset wins over any request presented in the same cycle.
    accept     = sram_en && !reset;
    do_write   = accept && sram_we && in_range;

    next_rdata = 32'h0;
    if (in_range) begin
`ifdef SRAM_RESP_WRITE_FWD_EN
      next_rdata = sram_we ? sram_wdata : mem[index];
`else
      // Nonblocking memory update means this is the pre-write word.
      next_rdata = mem[index];
`endif
    end
  end

  assign unused_offset_low = ^offset[1:0];

  // Memory array: never reset or cleared.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[index] <= sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rdata <= 32'h0;
      err        <= 1'b0;
      err_addr   <= 32'h0;
      err_cnt    <= 8'h0;
      rd_cnt     <= 32'h0;
      wr_cnt     <= 32'h0;
    end else if (accept) begin
      sram_rdata <= next_rdata;

      if (sram_we) begin
        wr_cnt <= wr_cnt + 32'd1;
      end else begin
        rd_cnt <= rd_cnt + 32'd1;
      end

      if (access_err) begin
        err <= 1'b1;
        // Only the first error after reset records its address.
        if (!err) begin
          err_addr <= sram_addr;
        end
        if (err_cnt != 8'hff) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//
// Bench for sram_responder with default parameters. A driver applies one
// stimulus per cycle on the falling edge and pushes the reference model's
// expected post-edge outputs into exp_q. A monitor, 1 time unit after each
// rising edge, pops one entry and compares every output. The model tracks
// memory as an associative array of written words. Words never written have
// unknown contents, so read data for them is not checked.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam logic [31:0] BASE_ADDR  = 32'h1c000000;
  localparam longint unsigned SPAN   = 64'd4 << ADDR_WIDTH;

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_en = 1'b0;
  logic        sram_we = 1'b0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic        err;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .err       (err),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  // reference model
  typedef struct packed {
    logic [31:0] rdata;
    logic        chk;
    logic        e;
    logic [31:0] ea;
    logic [7:0]  ec;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_rdata = 32'h0;
  logic        m_chk = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_ea = 32'h0;
  int unsigned m_ec = 0;
  logic [31:0] m_rd = 32'h0;
  logic [31:0] m_wr = 32'h0;

  int n_vec = 0;
  int n_miss = 0;

  task automatic model_step(input bit rst, input bit en, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    int unsigned idx;
    bit          inr;
    exp_t        e;
    if (rst) begin
      m_rdata = 0; m_chk = 1; m_err = 0; m_ea = 0; m_ec = 0; m_rd = 0; m_wr = 0;
    end else if (en) begin
      off = addr - BASE_ADDR;
      inr = longint'(off) < SPAN;
      idx = off / 4;
      if (we) m_wr = m_wr + 1;
      else    m_rd = m_rd + 1;
      if (!inr || (addr % 4) != 0) begin
        if (!m_err) m_ea = addr;
        m_err = 1;
        if (m_ec < 255) m_ec = m_ec + 1;
      end
      if (!inr) begin
        m_rdata = 0; m_chk = 1;
      end else begin
`ifdef SRAM_RESP_WRITE_FWD_EN
        if (we) begin
          m_rdata = wdata; m_chk = 1;
        end else
`endif
        if (m_mem.exists(idx)) begin
          m_rdata = m_mem[idx]; m_chk = 1;
        end else begin
          m_rdata = 0; m_chk = 0;
        end
        if (we) m_mem[idx] = wdata;
      end
    end
    e.rdata = m_rdata; e.chk = m_chk; e.e = m_err; e.ea = m_ea;
    e.ec = 8'(m_ec); e.rd = m_rd; e.wr = m_wr;
    exp_q.push_back(e);
  endtask

  // driver
  task automatic step(input bit rst, input bit en, input bit we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    model_step(rst, en, we, addr, wdata);
    reset      = rst;
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wdata;
  endtask

  task automatic rd(input logic [31:0] addr);
    step(0, 1, 0, addr, $urandom);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    step(0, 1, 1, addr, data);
  endtask

  task automatic idle();
    step(0, 0, $urandom_range(0, 1), $urandom, $urandom);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1, 0, 0, 32'h0, 32'h0);
  endtask

  // scoreboard / monitor
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) check("sram_rdata", sram_rdata, e.rdata);
      check("err", {31'h0, err}, {31'h0, e.e});
      check("err_addr", err_addr, e.ea);
      check("err_cnt", {24'h0, err_cnt}, {24'h0, e.ec});
      check("rd_cnt", rd_cnt, e.rd);
      check("wr_cnt", wr_cnt, e.wr);
    end
  end

  // stimulus
  initial begin
    int unsigned r;
    logic [31:0] a;

    do_reset(3);

    // Write then read back the same word.
    wr(32'h1c000010, 32'hdeadbeef);
    rd(32'h1c000010);
    idle();
    idle();

    // Back-to-back writes to one word: shows write-first vs read-first.
    wr(32'h1c000020, 32'h11111111);
    wr(32'h1c000020, 32'h22222222);
    rd(32'h1c000020);

    // Reset colliding with a write must drop the write.
    wr(32'h1c000000, 32'h00000077);
    step(1, 1, 1, 32'h1c000000, 32'h00000005);
    rd(32'h1c000000);

    // Misaligned in-range read uses the word index.
    wr(32'h1c000004, 32'ha5a5a5a5);
    rd(32'h1c000006);

    // Out-of-range reads at both ends.
    do_reset(1);
    rd(32'h00000000);
    rd(32'h1c040000);
    rd(BASE_ADDR - 32'd4);
    rd(BASE_ADDR + 32'(SPAN) - 32'd4);
    wr(BASE_ADDR + 32'(SPAN), 32'h12345678);

    // Error counter saturation.
    do_reset(1);
    for (int i = 0; i < 300; i++) rd(32'h00000000 + 32'(i * 4));

    // Randomized traffic.
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 19);
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE_ADDR + 32'(SPAN) + 32'($urandom_range(0, 7));
        2:       a = BASE_ADDR - 32'($urandom_range(1, 8));
        3:       a = BASE_ADDR + 32'(SPAN) - 32'd4 + 32'($urandom_range(0, 3));
        default: a = BASE_ADDR + 32'($urandom_range(0, 31) * 4)
                     + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      endcase
      if (r == 0)      step(1, $urandom_range(0, 1), $urandom_range(0, 1), a, $urandom);
      else if (r < 5)  idle();
      else             step(0, 1, $urandom_range(0, 1), a, $urandom);
    end

    idle();
    idle();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
